// File: rtl/ysyx_23060201_rf_pkg.sv
// Shared constants for the NPC register file with scoreboard.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ysyx_23060201_rf_pkg;

    localparam int DEF_ADDR_WIDTH = 5;   // RV32I; use 4 for RV32E
    localparam int DEF_DATA_WIDTH = 32;
    localparam int REG_ZERO       = 0;   // hardwired-zero register index

    // Number of architectural registers for a given index width.
    function automatic int RF_DEPTH(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/ysyx_23060201_regfile_sb_scoreboard.sv
// Per-register busy tracking: busy vector, busy count, sticky spurious-writeback flag.
// Latency: busy set/clear lands on the next edge; alloc_ready is combinational.
// Backpressure: alloc_ready low while the claimed register is busy and not being written back.
module ysyx_23060201_scoreboard
    import ysyx_23060201_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_alloc_valid,
    input  logic [ADDR_WIDTH-1:0]            i_alloc_addr,
    output logic                             o_alloc_ready,
    input  logic                             i_wen,
    input  logic [ADDR_WIDTH-1:0]            i_waddr,
    output logic [RF_DEPTH(ADDR_WIDTH)-1:0]  o_busy,
    output logic [ADDR_WIDTH:0]              o_busy_cnt,
    output logic                             o_wb_err
);

    localparam int                    DEPTH   = RF_DEPTH(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ZERO    = ADDR_WIDTH'(REG_ZERO);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);

    logic [DEPTH-1:0]    r_busy;
    logic [ADDR_WIDTH:0] r_busy_cnt;
    logic                r_wb_err;

    logic w_wr_hit;   // writeback to a real register
    logic w_acc;      // claim accepted on a real register
    logic w_inc;      // claim turns a clear bit into a set bit
    logic w_dec;      // writeback clears a set bit that is not re-claimed this cycle

    assign w_wr_hit      = i_wen && (i_waddr != ZERO);
    // A busy destination can be re-claimed in the very cycle its writeback retires.
    assign o_alloc_ready = (i_alloc_addr == ZERO) || !r_busy[i_alloc_addr] ||
                           (i_wen && (i_waddr == i_alloc_addr));
    assign w_acc         = i_alloc_valid && o_alloc_ready && (i_alloc_addr != ZERO);
    assign w_inc         = w_acc && !r_busy[i_alloc_addr];
    assign w_dec         = w_wr_hit && r_busy[i_waddr] &&
                           !(w_acc && (i_alloc_addr == i_waddr));

    // Busy bits, running count and sticky error; a new claim overrides a same-address clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
            r_wb_err   <= 1'b0;
        end else begin
            if (w_wr_hit) begin
                r_busy[i_waddr] <= 1'b0;
            end
            if (w_acc) begin
                r_busy[i_alloc_addr] <= 1'b1;
            end
            if (w_inc && !w_dec) begin
                r_busy_cnt <= r_busy_cnt + CNT_ONE;
            end else if (w_dec && !w_inc) begin
                r_busy_cnt <= r_busy_cnt - CNT_ONE;
            end
            if (w_wr_hit && !r_busy[i_waddr]) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_busy_cnt = r_busy_cnt;
    assign o_wb_err   = r_wb_err;

endmodule

// File: rtl/ysyx_23060201_regfile_sb.sv
// GPR file with NR_READ bypassed read ports, hardwired x0 and an integrated scoreboard.
// Latency: reads combinational; writes visible next cycle (same cycle through bypass).
// Backpressure: rbusy flags a pending source write; alloc_ready gates destination claims.
module ysyx_23060201_regfile_sb
    import ysyx_23060201_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NR_READ    = 2,
    parameter int BYPASS     = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NR_READ-1:0]              i_ren,
    input  logic [NR_READ*ADDR_WIDTH-1:0]   i_raddr,
    output logic [NR_READ*DATA_WIDTH-1:0]   o_rdata,
    output logic [NR_READ-1:0]              o_rbusy,
    input  logic                            i_alloc_valid,
    input  logic [ADDR_WIDTH-1:0]           i_alloc_addr,
    output logic                            o_alloc_ready,
    input  logic                            i_wen,
    input  logic [ADDR_WIDTH-1:0]           i_waddr,
    input  logic [DATA_WIDTH-1:0]           i_wdata,
    output logic [ADDR_WIDTH:0]             o_busy_cnt,
    output logic                            o_wb_err
);

    localparam int                    DEPTH = RF_DEPTH(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ZERO  = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      w_busy;
    logic [ADDR_WIDTH-1:0] w_ra;

    ysyx_23060201_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sb (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_alloc_valid (i_alloc_valid),
        .i_alloc_addr  (i_alloc_addr),
        .o_alloc_ready (o_alloc_ready),
        .i_wen         (i_wen),
        .i_waddr       (i_waddr),
        .o_busy        (w_busy),
        .o_busy_cnt    (o_busy_cnt),
        .o_wb_err      (o_wb_err)
    );

    // Data array: full synchronous clear on reset, x0 never written.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_regs[k] <= '0;
            end
        end else if (i_wen && (i_waddr != ZERO)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read muxes: disabled/x0 read 0 and not busy; writeback forwarding beats the array.
    always_comb begin
        o_rdata = '0;
        o_rbusy = '0;
        w_ra    = '0;
        for (int i = 0; i < NR_READ; i++) begin
            w_ra = i_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (i_ren[i] && (w_ra != ZERO)) begin
                if ((BYPASS != 0) && i_wen && (i_waddr == w_ra)) begin
                    o_rdata[i*DATA_WIDTH +: DATA_WIDTH] = i_wdata;
                end else begin
                    o_rdata[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[w_ra];
                    o_rbusy[i]                          = w_busy[w_ra];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060201_regfile_sb.sv
// Directed bench for the register file with scoreboard (RV32I, RV32E/3-port, no-bypass views).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// All expected values are hand-computed constants.
module tb_ysyx_23060201_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (defaults) plus a BYPASS=0 twin sharing its inputs.
    logic        rst, alloc_valid, alloc_ready, wen, wb_err;
    logic [1:0]  ren, rbusy;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [4:0]  alloc_addr, waddr;
    logic [31:0] wdata;
    logic [5:0]  busy_cnt;

    logic [63:0] nb_rdata;
    logic [1:0]  nb_rbusy;
    logic        nb_alloc_ready, nb_wb_err;
    logic [5:0]  nb_busy_cnt;

    // RV32E, three read ports.
    logic        e_rst, e_alloc_valid, e_alloc_ready, e_wen, e_wb_err;
    logic [2:0]  e_ren, e_rbusy;
    logic [11:0] e_raddr;
    logic [95:0] e_rdata;
    logic [3:0]  e_alloc_addr, e_waddr;
    logic [31:0] e_wdata;
    logic [4:0]  e_busy_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_23060201_regfile_sb dut (
        .i_clk(clk), .i_rst(rst), .i_ren(ren), .i_raddr(raddr), .o_rdata(rdata), .o_rbusy(rbusy),
        .i_alloc_valid(alloc_valid), .i_alloc_addr(alloc_addr), .o_alloc_ready(alloc_ready),
        .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .o_busy_cnt(busy_cnt), .o_wb_err(wb_err)
    );

    ysyx_23060201_regfile_sb #(.BYPASS(0)) dut_nb (
        .i_clk(clk), .i_rst(rst), .i_ren(ren), .i_raddr(raddr), .o_rdata(nb_rdata), .o_rbusy(nb_rbusy),
        .i_alloc_valid(alloc_valid), .i_alloc_addr(alloc_addr), .o_alloc_ready(nb_alloc_ready),
        .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .o_busy_cnt(nb_busy_cnt), .o_wb_err(nb_wb_err)
    );

    ysyx_23060201_regfile_sb #(.ADDR_WIDTH(4), .NR_READ(3)) dut_e (
        .i_clk(clk), .i_rst(e_rst), .i_ren(e_ren), .i_raddr(e_raddr), .o_rdata(e_rdata), .o_rbusy(e_rbusy),
        .i_alloc_valid(e_alloc_valid), .i_alloc_addr(e_alloc_addr), .o_alloc_ready(e_alloc_ready),
        .i_wen(e_wen), .i_waddr(e_waddr), .i_wdata(e_wdata), .o_busy_cnt(e_busy_cnt), .o_wb_err(e_wb_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Port 0 reads a0, port 1 reads a1.
    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    initial begin
        rst = 1'b1; ren = '0; raddr = '0; alloc_valid = 1'b0; alloc_addr = '0;
        wen = 1'b0; waddr = '0; wdata = '0;
        e_rst = 1'b1; e_ren = '0; e_raddr = '0; e_alloc_valid = 1'b0; e_alloc_addr = '0;
        e_wen = 1'b0; e_waddr = '0; e_wdata = '0;
        tick();
        tick();
        rst = 1'b0;
        e_rst = 1'b0;

        // Reset state across the whole array.
        ren = 2'b11;
        alloc_addr = 5'd5;
        for (int r = 0; r < 32; r++) begin
            logic [4:0] a;
            a = r[4:0];
            rd(a, a);
            #1;
            chk("rst_rd0", rdata[31:0], 0);
            chk("rst_rd1", rdata[63:32], 0);
            chk("rst_rbusy", rbusy, 0);
        end
        chk("rst_cnt", busy_cnt, 0);
        chk("rst_ready", alloc_ready, 1);
        chk("rst_err", wb_err, 0);

        // Claim x5, then retire it with bypass.
        alloc_valid = 1'b1; alloc_addr = 5'd5;
        #1 chk("x5_ready", alloc_ready, 1);
        tick();
        alloc_valid = 1'b0; rd(5'd5, 5'd0);
        #1;
        chk("x5_rbusy", rbusy, 2'b01);
        chk("x5_cnt", busy_cnt, 1);
        chk("x5_blocked", alloc_ready, 0);
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        #1;
        chk("x5_byp_data", rdata[31:0], 32'hDEADBEEF);
        chk("x5_byp_rbusy", rbusy, 0);
        chk("x5_wb_ready", alloc_ready, 1);
        chk("nb_old_data", nb_rdata[31:0], 0);
        chk("nb_old_rbusy", nb_rbusy, 2'b01);
        tick();
        wen = 1'b0;
        #1;
        chk("x5_cnt_after", busy_cnt, 0);
        chk("x5_arr_data", rdata[31:0], 32'hDEADBEEF);
        chk("x5_arr_rbusy", rbusy, 0);
        chk("nb_new_data", nb_rdata[31:0], 32'hDEADBEEF);
        chk("nb_new_rbusy", nb_rbusy, 0);
        chk("x5_err", wb_err, 0);

        // x7: WAW block, then re-claim in the writeback cycle.
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        tick();
        #1 chk("x7_blocked", alloc_ready, 0);
        tick();
        chk("x7_cnt_held", busy_cnt, 1);
        wen = 1'b1; waddr = 5'd7; wdata = 32'h77;
        #1 chk("x7_reclaim_ready", alloc_ready, 1);
        tick();
        alloc_valid = 1'b0; wen = 1'b0; rd(5'd7, 5'd0);
        #1;
        chk("x7_cnt_same", busy_cnt, 1);
        chk("x7_still_busy", rbusy, 2'b01);
        chk("x7_data", rdata[31:0], 32'h77);
        chk("x7_err", wb_err, 0);
        wen = 1'b1; waddr = 5'd7; wdata = 32'h78;
        tick();
        wen = 1'b0;
        #1;
        chk("x7_cnt_clear", busy_cnt, 0);
        chk("x7_rbusy_clear", rbusy, 0);

        // x0: writes and claims have no effect, no bypass of x0.
        wen = 1'b1; waddr = 5'd0; wdata = 32'h1234;
        alloc_valid = 1'b1; alloc_addr = 5'd0; rd(5'd0, 5'd0);
        #1;
        chk("x0_ready", alloc_ready, 1);
        chk("x0_nobyp", rdata, 0);
        tick();
        wen = 1'b0; alloc_valid = 1'b0;
        #1;
        chk("x0_data", rdata, 0);
        chk("x0_rbusy", rbusy, 0);
        chk("x0_cnt", busy_cnt, 0);
        chk("x0_err", wb_err, 0);

        // Spurious writeback to x3 sets the sticky error.
        wen = 1'b1; waddr = 5'd3; wdata = 32'h55;
        tick();
        wen = 1'b0; rd(5'd0, 5'd3);
        #1;
        chk("x3_data", rdata[63:32], 32'h55);
        chk("x3_err", wb_err, 1);
        chk("x3_cnt", busy_cnt, 0);
        tick();
        chk("x3_err_held", wb_err, 1);

        // Reset with write/claim present: both ignored.
        rst = 1'b1; wen = 1'b1; waddr = 5'd4; wdata = 32'h44;
        alloc_valid = 1'b1; alloc_addr = 5'd6;
        tick();
        rst = 1'b0; wen = 1'b0; alloc_valid = 1'b0; rd(5'd4, 5'd3);
        #1;
        chk("rst2_err", wb_err, 0);
        chk("rst2_x3", rdata[63:32], 0);
        chk("rst2_x4", rdata[31:0], 0);
        chk("rst2_cnt", busy_cnt, 0);
        rd(5'd6, 5'd5);
        #1;
        chk("rst2_x6_rbusy", rbusy, 0);
        chk("rst2_x5", rdata[63:32], 0);

        // Fill every register.
        for (int a = 1; a < 32; a++) begin
            alloc_valid = 1'b1; alloc_addr = a[4:0];
            tick();
        end
        alloc_valid = 1'b0; alloc_addr = 5'd9; rd(5'd9, 5'd31);
        #1;
        chk("full_cnt", busy_cnt, 31);
        chk("nb_full_cnt", nb_busy_cnt, 31);
        chk("full_ready", alloc_ready, 0);
        chk("full_rbusy", rbusy, 2'b11);
        wen = 1'b1; waddr = 5'd31; wdata = 32'h31;
        tick();
        wen = 1'b0;
        #1 chk("full_dec", busy_cnt, 30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("full_rst_cnt", busy_cnt, 0);
        chk("full_rst_ready", alloc_ready, 1);
        chk("full_rst_rbusy", rbusy, 0);
        wen = 1'b1; waddr = 5'd9; wdata = 32'h9;
        tick();
        wen = 1'b0;
        #1 chk("stale_wb_err", wb_err, 1);

        // RV32E, three ports.
        for (int a = 1; a < 16; a++) begin
            e_alloc_valid = 1'b1; e_alloc_addr = a[3:0];
            tick();
        end
        e_alloc_valid = 1'b0; e_alloc_addr = 4'd3;
        #1;
        chk("e_full_cnt", e_busy_cnt, 15);
        chk("e_full_ready", e_alloc_ready, 0);
        e_ren = 3'b111; e_raddr = {4'd5, 4'd5, 4'd5};
        e_wen = 1'b1; e_waddr = 4'd5; e_wdata = 32'hA5A50005;
        #1;
        chk("e_byp_p0", e_rdata[31:0], 32'hA5A50005);
        chk("e_byp_p1", e_rdata[63:32], 32'hA5A50005);
        chk("e_byp_p2", e_rdata[95:64], 32'hA5A50005);
        chk("e_byp_rbusy", e_rbusy, 0);
        tick();
        e_waddr = 4'd9; e_wdata = 32'h9999; e_raddr = {4'd9, 4'd1, 4'd5};
        #1;
        chk("e_p2_byp", e_rdata[95:64], 32'h9999);
        chk("e_p1_busy_data", e_rdata[63:32], 0);
        chk("e_p0_arr", e_rdata[31:0], 32'hA5A50005);
        chk("e_rbusy_mix", e_rbusy, 3'b010);
        e_ren = 3'b101;
        #1;
        chk("e_ren_off_data", e_rdata[63:32], 0);
        chk("e_ren_off_rbusy", e_rbusy, 0);
        tick();
        e_wen = 1'b0;
        #1;
        chk("e_cnt_13", e_busy_cnt, 13);
        chk("e_err", e_wb_err, 0);
        e_rst = 1'b1;
        tick();
        e_rst = 1'b0;
        #1;
        chk("e_rst_cnt", e_busy_cnt, 0);
        chk("e_rst_ready", e_alloc_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060201_regfile_sb.md
# ysyx_23060201_regfile_sb

Parametrised general-purpose register file with integrated scoreboard, replacing the fixed two-read-port GPR in the NPC core. Provides `NR_READ` read ports with write-to-read bypass, a hardwired-zero `x0`, true synchronous reset of every register, and per-register busy tracking. Decode uses the busy tracking to stall on RAW hazards and to block WAW issue when writeback is multi-cycle. Sits between IDU (read/alloc) and WBU (write).

## Interface
- `ADDR_WIDTH`, 5, register index width (5 = RV32I, 4 = RV32E); depth = 2**ADDR_WIDTH
- `DATA_WIDTH`, 32, register width
- `NR_READ`, 2, number of read ports (≥1)
- `BYPASS`, 1, 1 = same-cycle writeback data forwarded to read ports
---
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, synchronous, active-high
- `ren` in NR_READ: per-port read enable
- `raddr` in NR_READ*ADDR_WIDTH: port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `rdata` out NR_READ*DATA_WIDTH: port i read data, same packing
- `rbusy` out NR_READ: port i source has a pending write (consumer must stall)
- `alloc_valid` in 1: issue wants to claim `alloc_addr` as destination
- `alloc_addr` in ADDR_WIDTH: destination being claimed
- `alloc_ready` out 1: claim accepted this cycle when high with `alloc_valid`
- `wen` in 1: writeback valid
- `waddr` in ADDR_WIDTH: writeback destination
- `wdata` in DATA_WIDTH: writeback data
- `busy_cnt` out ADDR_WIDTH+1: number of registers currently busy
- `wb_err` out 1: sticky; a writeback hit a non-busy nonzero register

## Operation
- Array: 2**ADDR_WIDTH × DATA_WIDTH; entry 0 is never written and always reads 0.
- Write: `wen && waddr!=0` → `reg[waddr] <= wdata`; clears `busy[waddr]`.
- Read port i, evaluated in priority order:
  - `ren[i]==0` → rdata 0, rbusy 0.
  - `raddr==0` → 0, rbusy 0.
  - BYPASS and `wen && waddr==raddr` → `wdata`, rbusy 0.
  - otherwise → `reg[raddr]`, `busy[raddr]`.
- Alloc:
  - `alloc_ready = (alloc_addr==0) | !busy[alloc_addr] | (wen && waddr==alloc_addr)`; purely combinational, no dependence on `alloc_valid`.
  - Accept = `alloc_valid && alloc_ready && alloc_addr!=0` → `busy[alloc_addr] <= 1`.
  - Alloc to x0 is accepted and has no effect.
- Simultaneous alloc and writeback to the same address: busy stays 1 (the new claim wins) and `busy_cnt` is unchanged.
- `busy_cnt`: incrementally updated counter.
  - +1 on an accepted alloc that sets a clear bit.
  - −1 on a writeback that clears a set bit.
  - Net 0 when both happen. Never a popcount.
  - Range 0..2**ADDR_WIDTH−1, so it never wraps.
- `wb_err` set when `wen && waddr!=0 && !busy[waddr]`; data is still written. Cleared only by `rst`.
- Mode BYPASS=0: read of the register being written returns old data and `rbusy` = its current busy bit.

## Timing
- Reads combinational; zero latency.
- Write data visible through the array the cycle after `wen`; same cycle via bypass only.
- Busy set visible the cycle after accept; busy clear same cycle (bypass) or next cycle (BYPASS=0).
- Reset: on a rising edge with `rst=1`:
  - all registers 0, all busy 0, `busy_cnt` 0, `wb_err` 0.
  - `wen` and alloc are ignored that cycle.
  - Afterwards `alloc_ready`=1 and all `rbusy`=0.
- Reset mid-operation discards all pending claims. A later `wen` to a now-clear register sets `wb_err`.

## Structure
- Package `ysyx_23060201_rf_pkg`: default ADDR/DATA widths, `REG_ZERO` constant, `RF_DEPTH` localparam function.
- Sub-module `ysyx_23060201_scoreboard`: busy vector, `busy_cnt`, `wb_err`, `alloc_ready`. Top holds the data array, read muxes and bypass.

## Test plan
- Reset, then read all 32 regs on both ports → all 0, rbusy 0, busy_cnt 0, alloc_ready 1.
- Alloc x5; next cycle read x5 → rbusy 1, busy_cnt 1. Then `wen` x5=0xDEADBEEF → same-cycle rdata 0xDEADBEEF, rbusy 0; next cycle busy_cnt 0.
- With x7 busy, alloc x7 without `wen` → alloc_ready 0, busy_cnt stays 1. Alloc x7 with `wen` x7 in the same cycle → ready 1, busy stays 1, count 1.
- `wen` x0=0x1234 and alloc x0 → x0 reads 0, busy_cnt 0, wb_err 0.
- `wen` x3=0x55 with x3 not busy → x3 reads 0x55 next cycle, wb_err 1 and held. Pulse `rst` → wb_err 0, x3 reads 0.
- Allocate x1..x31 over consecutive cycles → busy_cnt 31. Assert `rst` → busy_cnt 0. Rerun with ADDR_WIDTH=4, NR_READ=3: 15 max, all three ports bypass correctly.
